// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared pipeline constants and the IF/ID bundle type.
package if_stage_pkg;
  localparam int WORD_W = 32;
  localparam int JIDX_W = 26;
  localparam logic [WORD_W-1:0] NOP_INST = 32'h0000_0000;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef struct packed {
    logic [WORD_W-1:0] pc4;
    logic [WORD_W-1:0] inst;
    logic              valid;
  } if_id_t;
  localparam if_id_t BUBBLE = '{pc4: '0, inst: NOP_INST, valid: 1'b0};
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; clk/rst, hold freezes, squash loads a bubble, d in, q out.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   hold,
  input  logic   squash,
  input  if_id_t d,
  output if_id_t q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= BUBBLE;
    else if (!hold) q <= squash ? BUBBLE : d;
endmodule

// File: rtl/if_stage.sv
// if_stage: PC, next-PC mux and IF/ID register; hazard controls in, imem address out, IF/ID bundle out.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              PCSrc,
  input  logic [WORD_W-1:0] BranchTarget,
  input  logic              Jump,
  input  logic [JIDX_W-1:0] JumpIndex,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_data,
  output logic [WORD_W-1:0] IFtoID_PC,
  output logic [WORD_W-1:0] IFtoID_inst,
  output logic              IFtoID_valid
);
  logic [WORD_W-1:0] pc, pc4, next_pc;
  if_id_t d, q;
  assign pc4 = pc + 32'd4;
  // jump target takes its top nibble from the PC+4 of the jump sitting in decode
  assign next_pc = Jump ? {q.pc4[31:28], JumpIndex, 2'b00}
                 : PCSrc ? (BranchTarget & 32'hFFFF_FFFC) : pc4;
  always_ff @(posedge clk or posedge rst)
    if (rst) pc <= RESET_PC & 32'hFFFF_FFFC;
    else if (!Stall) pc <= next_pc;
  assign d = '{pc4: pc4, inst: imem_data, valid: 1'b1};
  // any redirect squashes the wrong-path fetch without needing Flush
  if_id_reg u_if_id (
    .clk(clk),
    .rst(rst),
    .hold(Stall),
    .squash(Jump | PCSrc | Flush),
    .d(d),
    .q(q)
  );
  assign imem_addr = pc;
  assign IFtoID_PC = q.pc4;
  assign IFtoID_inst = q.inst;
  assign IFtoID_valid = q.valid;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed test-plan scenarios plus randomized controls against a behavioural model.
module tb_if_stage;
  import if_stage_pkg::*;
  logic clk = 0, rst = 1, Stall = 0, Flush = 0, PCSrc = 0, Jump = 0;
  logic [31:0] BranchTarget = 0;
  logic [25:0] JumpIndex = 0;
  logic [31:0] imem_addr, imem_data, IFtoID_PC, IFtoID_inst;
  logic IFtoID_valid;
  int checks = 0, failures = 0;
  logic [31:0] m_pc, m_pc4, m_inst;
  logic m_valid;
  if_stage dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .PCSrc(PCSrc),
    .BranchTarget(BranchTarget), .Jump(Jump), .JumpIndex(JumpIndex),
    .imem_addr(imem_addr), .imem_data(imem_data), .IFtoID_PC(IFtoID_PC),
    .IFtoID_inst(IFtoID_inst), .IFtoID_valid(IFtoID_valid)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] imem(input logic [31:0] a);
    return a == 0 ? 32'h2008_0005 : a == 4 ? 32'h2009_0003 : (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  assign imem_data = imem(imem_addr);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic m_reset;
    m_pc = 0; m_pc4 = 0; m_inst = NOP_INST; m_valid = 0;
  endtask
  task automatic m_edge;
    logic [31:0] nxt;
    if (Stall) return;
    if (Jump || PCSrc || Flush) begin
      nxt = Jump ? {m_pc4[31:28], JumpIndex, 2'b00}
          : PCSrc ? {BranchTarget[31:2], 2'b00} : m_pc + 32'd4;
      m_pc4 = 0; m_inst = NOP_INST; m_valid = 0;
    end else begin
      nxt = m_pc + 32'd4;
      m_pc4 = nxt; m_inst = imem(m_pc); m_valid = 1;
    end
    m_pc = nxt;
  endtask
  task automatic cmp_all(input string tag);
    chk({tag, ".pc"}, imem_addr, m_pc);
    chk({tag, ".pc4"}, IFtoID_PC, m_pc4);
    chk({tag, ".inst"}, IFtoID_inst, m_inst);
    chk({tag, ".valid"}, {31'b0, IFtoID_valid}, {31'b0, m_valid});
  endtask
  task automatic step(input logic s, f, b, j, input logic [31:0] bt, input logic [25:0] ji);
    Stall = s; Flush = f; PCSrc = b; Jump = j; BranchTarget = bt; JumpIndex = ji;
    @(posedge clk);
    m_edge();
    #1;
    cmp_all("step");
    Stall = 0; Flush = 0; PCSrc = 0; Jump = 0;
  endtask
  task automatic async_reset;
    rst = 1;
    #1;
    m_reset();
    cmp_all("areset");
    #2 rst = 0;
  endtask
  initial begin
    m_reset();
    #12;
    cmp_all("reset");
    chk("reset_valid", {31'b0, IFtoID_valid}, 32'd0);
    rst = 0;
    step(0, 0, 0, 0, 0, 0);
    chk("e1_inst", IFtoID_inst, 32'h2008_0005);
    chk("e1_pc4", IFtoID_PC, 32'd4);
    chk("e1_valid", {31'b0, IFtoID_valid}, 32'd1);
    step(0, 0, 0, 0, 0, 0);
    chk("e2_inst", IFtoID_inst, 32'h2009_0003);
    chk("e2_pc", imem_addr, 32'h8);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("pre_stall_pc", imem_addr, 32'h10);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 32'h80, 0);
    chk("stall_pc", imem_addr, 32'h10);
    chk("stall_pc4", IFtoID_PC, 32'h10);
    step(0, 0, 0, 0, 0, 0);
    chk("pre_br_pc4", IFtoID_PC, 32'h14);
    step(0, 0, 1, 0, 32'h40, 0);
    chk("br_pc", imem_addr, 32'h40);
    chk("br_valid", {31'b0, IFtoID_valid}, 32'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("br_pc4", IFtoID_PC, 32'h44);
    step(0, 0, 1, 0, 32'h1000_0004, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("pre_j_pc4", IFtoID_PC, 32'h1000_0008);
    step(0, 0, 1, 1, 32'h80, 26'h000_0100);
    chk("j_pc", imem_addr, 32'h1000_0400);
    chk("j_valid", {31'b0, IFtoID_valid}, 32'd0);
    step(0, 0, 1, 0, 32'hFFFF_FFFF, 0);
    chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    step(0, 1, 0, 0, 0, 0);
    chk("wrap_pc", imem_addr, 32'h0);
    chk("flush_inst", IFtoID_inst, NOP_INST);
    chk("flush_valid", {31'b0, IFtoID_valid}, 32'd0);
    step(0, 0, 1, 0, 32'h20, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("pre_ar_pc", imem_addr, 32'h24);
    chk("pre_ar_valid", {31'b0, IFtoID_valid}, 32'd1);
    #2;
    async_reset();
    chk("ar_pc", imem_addr, 32'h0);
    chk("ar_valid", {31'b0, IFtoID_valid}, 32'd0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 3) async_reset();
      else step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
                $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
                $urandom, 26'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage. Holds the program counter, drives the instruction-memory read address, and registers the fetched instruction and its PC+4 into the IF/ID pipeline register consumed by decode. Handles hazard-unit stalls, control-flow redirects (branch and jump resolved in decode), and bubble insertion.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- NOP_INST, 32'h0000_0000, bubble instruction (sll $0,$0,0).

- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- Stall  in  1  hazard-unit stall: hold PC and IF/ID.
- Flush  in  1  squash: load a bubble into IF/ID.
- PCSrc  in  1  taken branch from decode: next PC = BranchTarget.
- BranchTarget  in  32  branch target from decode.
- Jump  in  1  jump from decode.
- JumpIndex  in  26  instr[25:0] of the jump in decode.
- imem_addr  out  32  instruction-memory byte address (= PC).
- imem_data  in  32  instruction word at imem_addr, combinational read.
- IFtoID_PC  out  32  PC+4 of the instruction in IF/ID.
- IFtoID_inst  out  32  instruction in IF/ID.
- IFtoID_valid  out  1  1 = real instruction, 0 = bubble.

## Operation
- PC register drives imem_addr directly; PC_plus4 = PC + 32'd4, modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- JumpTarget = {IFtoID_PC[31:28], JumpIndex, 2'b00}. Uses the PC+4 of the jump currently in decode.
- Per-edge priority, highest first:
  - Stall=1: PC, IFtoID_PC, IFtoID_inst, IFtoID_valid all hold. Jump, PCSrc and Flush are ignored that cycle.
  - Jump=1: PC <= JumpTarget; IF/ID <= bubble.
  - PCSrc=1: PC <= {BranchTarget[31:2], 2'b00}; IF/ID <= bubble.
  - Flush=1: PC <= PC_plus4; IF/ID <= bubble.
  - Otherwise: PC <= PC_plus4; IFtoID_PC <= PC_plus4; IFtoID_inst <= imem_data; IFtoID_valid <= 1.
- Jump and PCSrc both 1: Jump wins.
- A redirect always squashes the wrong-path instruction being fetched. The hazard unit does not also need to assert Flush.
- Bubble contents: IFtoID_PC = 0, IFtoID_inst = NOP_INST, IFtoID_valid = 0.
- PC[1:0] is always 0. Target low bits are discarded.
- No state machine beyond the PC and IF/ID registers. The valid bit is the only control state.

## Timing
- Reset values (asynchronous, immediate on rst rise): PC = RESET_PC, IFtoID_PC = 0, IFtoID_inst = NOP_INST, IFtoID_valid = 0.
- Reset asserted mid-operation overrides every input and discards any in-flight instruction.
- First rising edge with rst=0 captures imem_data at RESET_PC into IF/ID.
- Fetch latency: the instruction at address A appears on IFtoID_inst exactly 1 cycle after PC = A.
- Redirect penalty: one bubble. The redirect is asserted in cycle N; the target instruction reaches IF/ID at edge N+2.
- imem_addr changes only on clock edges or reset. imem_data must settle within the same cycle.
- Stall held for k cycles freezes all outputs for k edges; fetch resumes unchanged afterwards.

## Structure
- Shared pipeline package holds: NOP_INST, the default RESET_PC, instruction field widths (32-bit word, 26-bit jump index), and the IF/ID bundle typedef {pc4, inst, valid}.
- One sub-module: if_id_reg, the IF/ID pipeline register with hold (Stall) and bubble-load (squash) controls.
- The PC register and next-PC mux live in if_stage.

## Test plan
- Reset/straight-line: rst pulse; imem returns 32'h2008_0005 at 0x0 and 32'h2009_0003 at 0x4.
  - During reset: outputs equal the reset values.
  - Edge 1: IFtoID_inst = 32'h2008_0005, IFtoID_PC = 4, valid = 1.
  - Edge 2: inst = 32'h2009_0003, PC = 8.
- Stall: assert Stall for 2 cycles with PC = 0x10.
  - PC stays 0x10 and the IF/ID contents are frozen.
  - Same result with PCSrc=1 raised during the stall.
- Branch: with IFtoID_PC = 0x14, pulse PCSrc=1 with BranchTarget = 0x40.
  - Next edge: PC = 0x40 and valid = 0.
  - Following edge: IFtoID_PC = 0x44.
- Jump beats branch: IFtoID_PC = 0x1000_0008, Jump=1 with JumpIndex = 26'h000_0100, PCSrc=1 with BranchTarget = 0x80.
  - PC = 0x1000_0400 and a bubble is inserted.
- Wrap and flush: PC = 32'hFFFF_FFFC.
  - Next edge: PC = 0.
  - Flush=1 in that cycle: IFtoID_inst = NOP_INST, valid = 0, and the PC still advances.
- Async reset mid-run: raise rst between clock edges at PC = 0x24.
  - Immediately: PC = RESET_PC and valid = 0, with no clock edge required.
